pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the five-stage pipeline. Watches the ID and EX stages and drives the PC and pipeline-register enables and flushes. It resolves load-use hazards, taken branches resolved in EX, and multi-cycle multiply/divide occupancy of EX. It also keeps saturating stall and flush counters for the test benches, alongside the register-file probes already in use.

---
 rtl/pipe_hazard_ctrl_if.sv | 36 +++
 rtl/pipe_hazard_ctrl.sv | 111 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle: ID/EX observation inputs and the pipeline enable/flush outputs.
// The sequencer takes the slave side; the pipeline (or bench) takes the master side.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic [4:0]       ex_rd;
  logic             ex_mem_read;
  logic             branch_taken;
  logic             md_start;
  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_bubble;
  logic             md_done;
  logic             busy;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rd, ex_mem_read, branch_taken, md_start,
    output pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_bubble, md_done, busy,
           stall_cnt, flush_cnt
  );

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rd, ex_mem_read, branch_taken, md_start,
    input  pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_bubble, md_done, busy,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: load-use stalls, EX branch flushes,
// multi-cycle mul/div freeze, plus saturating stall and flush event counters.
module pipe_hazard_ctrl #(
   parameter int unsigned MD_CYCLES = 4,
   parameter int unsigned CNT_W     = 16
) (
   input logic              clk,
   input logic              rst,
   pipe_hazard_ctrl_if.slave bus
);

   typedef enum logic {StRun, StMdWait} state_e;

   localparam logic [7:0] MdInit = 8'(MD_CYCLES - 2);

   state_e           state_q, state_d;
   logic [7:0]       md_cnt_q, md_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             load_use;
   logic             stall_evt;
   logic             flush_evt;

   assign load_use = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                     ((bus.id_uses_rs && (bus.id_rs == bus.ex_rd)) ||
                      (bus.id_uses_rt && (bus.id_rt == bus.ex_rd)));

   always_comb begin
      state_d          = state_q;
      md_cnt_d         = md_cnt_q;
      stall_evt        = 1'b0;
      flush_evt        = 1'b0;
      bus.pc_en        = 1'b1;
      bus.ifid_en      = 1'b1;
      bus.idex_en      = 1'b1;
      bus.ifid_flush   = 1'b0;
      bus.idex_flush   = 1'b0;
      bus.exmem_bubble = 1'b0;
      bus.md_done      = 1'b0;
      bus.busy         = 1'b0;

      if (rst) begin
         // Hold everything and squash in-flight contents while reset is applied.
         bus.pc_en        = 1'b0;
         bus.ifid_en      = 1'b0;
         bus.idex_en      = 1'b0;
         bus.ifid_flush   = 1'b1;
         bus.idex_flush   = 1'b1;
         bus.exmem_bubble = 1'b1;
      end else begin
         unique case (state_q)
            StRun: begin
               if (bus.branch_taken) begin
                  bus.ifid_flush = 1'b1;
                  bus.idex_flush = 1'b1;
                  flush_evt      = 1'b1;
               end else if (bus.md_start) begin
                  bus.pc_en        = 1'b0;
                  bus.ifid_en      = 1'b0;
                  bus.idex_en      = 1'b0;
                  bus.exmem_bubble = 1'b1;
                  stall_evt        = 1'b1;
                  state_d          = StMdWait;
                  md_cnt_d         = MdInit;
               end else if (load_use) begin
                  bus.pc_en      = 1'b0;
                  bus.ifid_en    = 1'b0;
                  bus.idex_flush = 1'b1;
                  stall_evt      = 1'b1;
               end
            end
            StMdWait: begin
               bus.pc_en        = 1'b0;
               bus.ifid_en      = 1'b0;
               bus.idex_en      = 1'b0;
               bus.exmem_bubble = 1'b1;
               bus.busy         = 1'b1;
               stall_evt        = 1'b1;
               if (md_cnt_q != 8'd0) begin
                  md_cnt_d = md_cnt_q - 8'd1;
               end else begin
                  bus.md_done = 1'b1;
                  state_d     = StRun;
               end
            end
            default: state_d = StRun;
         endcase
      end

      stall_cnt_d = (stall_evt && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
      flush_cnt_d = (flush_evt && (flush_cnt_q != '1)) ? flush_cnt_q + 1'b1 : flush_cnt_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StRun;
         md_cnt_q    <= 8'd0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         md_cnt_q    <= md_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign bus.stall_cnt = stall_cnt_q;
   assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: vector table plus hand-written mul/div, reset and saturation
// sequences; expected values go through a scoreboard queue and are checked mid-cycle.
module tb_pipe_hazard_ctrl;

   localparam int unsigned CNT_W = 4;

   // Control word order: pc_en ifid_en idex_en ifid_flush idex_flush exmem_bubble md_done busy
   localparam logic [7:0] CtlNorm   = 8'b1110_0000;
   localparam logic [7:0] CtlRst    = 8'b0001_1100;
   localparam logic [7:0] CtlLdUse  = 8'b0010_1000;
   localparam logic [7:0] CtlBranch = 8'b1111_1000;
   localparam logic [7:0] CtlMdGo   = 8'b0000_0100;
   localparam logic [7:0] CtlMdWait = 8'b0000_0101;
   localparam logic [7:0] CtlMdDone = 8'b0000_0111;

   typedef struct packed {
      logic       rst;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       urs;
      logic       urt;
      logic [4:0] rd;
      logic       mr;
      logic       br;
      logic       md;
      logic [7:0] ctl;
      logic [3:0] st;
      logic [3:0] fl;
   } vec_t;

   typedef struct packed {
      logic [7:0] ctl;
      logic [3:0] st;
      logic [3:0] fl;
   } exp_t;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   exp_t sb[$];
   vec_t tbl[12];

   pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

   pipe_hazard_ctrl #(
      .MD_CYCLES(4),
      .CNT_W    (CNT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mkv(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                                input logic urs, input logic urt, input logic [4:0] rd,
                                input logic mr, input logic br, input logic md,
                                input logic [7:0] ctl, input logic [3:0] st,
                                input logic [3:0] fl);
      vec_t v;
      v = '{rst: r, rs: rs, rt: rt, urs: urs, urt: urt, rd: rd, mr: mr, br: br, md: md,
            ctl: ctl, st: st, fl: fl};
      return v;
   endfunction

   task automatic drive(input vec_t v);
      rst              = v.rst;
      bus.id_rs        = v.rs;
      bus.id_rt        = v.rt;
      bus.id_uses_rs   = v.urs;
      bus.id_uses_rt   = v.urt;
      bus.ex_rd        = v.rd;
      bus.ex_mem_read  = v.mr;
      bus.branch_taken = v.br;
      bus.md_start     = v.md;
   endtask

   task automatic check(input string tag, input int idx);
      exp_t       e;
      logic [7:0] got;
      got = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.ifid_flush, bus.idex_flush,
             bus.exmem_bubble, bus.md_done, bus.busy};
      total++;
      if (sb.size() == 0) begin
         bad++;
         $display("FAIL %s%0d scoreboard empty", tag, idx);
         return;
      end
      e = sb.pop_front();
      if (got !== e.ctl) begin
         bad++;
         $display("FAIL %s%0d ctl got=%b want=%b", tag, idx, got, e.ctl);
      end
      total++;
      if (bus.stall_cnt !== e.st || bus.flush_cnt !== e.fl) begin
         bad++;
         $display("FAIL %s%0d counters got stall=%0d flush=%0d want stall=%0d flush=%0d",
                  tag, idx, bus.stall_cnt, bus.flush_cnt, e.st, e.fl);
      end
   endtask

   // Drive on the falling edge, check 2ns later, the rising edge then commits the step.
   task automatic apply(input vec_t v, input string tag, input int idx);
      @(negedge clk);
      drive(v);
      sb.push_back('{ctl: v.ctl, st: v.st, fl: v.fl});
      #2;
      check(tag, idx);
   endtask

   task automatic rst_pulse();
      @(negedge clk);
      drive(mkv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, CtlRst, 4'd0, 4'd0));
   endtask

   initial begin
      total = 0;
      bad   = 0;
      drive(mkv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, CtlRst, 4'd0, 4'd0));
      @(negedge clk);

      //            rst   rs     rt     urs   urt   rd     mr    br    md    ctl        st    fl
      tbl[0]  = mkv(1'b1, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, CtlRst,    4'd0, 4'd0);
      tbl[1]  = mkv(1'b0, 5'd21, 5'd0,  1'b1, 1'b0, 5'd21, 1'b1, 1'b0, 1'b0, CtlLdUse,  4'd0, 4'd0);
      tbl[2]  = mkv(1'b0, 5'd21, 5'd0,  1'b1, 1'b0, 5'd21, 1'b0, 1'b0, 1'b0, CtlNorm,   4'd1, 4'd0);
      tbl[3]  = mkv(1'b0, 5'd0,  5'd0,  1'b1, 1'b1, 5'd0,  1'b1, 1'b0, 1'b0, CtlNorm,   4'd1, 4'd0);
      tbl[4]  = mkv(1'b0, 5'd21, 5'd3,  1'b0, 1'b1, 5'd21, 1'b1, 1'b0, 1'b0, CtlNorm,   4'd1, 4'd0);
      tbl[5]  = mkv(1'b0, 5'd23, 5'd21, 1'b1, 1'b1, 5'd21, 1'b0, 1'b0, 1'b0, CtlNorm,   4'd1, 4'd0);
      tbl[6]  = mkv(1'b0, 5'd4,  5'd9,  1'b1, 1'b1, 5'd9,  1'b1, 1'b0, 1'b0, CtlLdUse,  4'd1, 4'd0);
      tbl[7]  = mkv(1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, CtlNorm,   4'd2, 4'd0);
      tbl[8]  = mkv(1'b0, 5'd21, 5'd0,  1'b1, 1'b0, 5'd21, 1'b1, 1'b1, 1'b0, CtlBranch, 4'd2, 4'd0);
      tbl[9]  = mkv(1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, CtlNorm,   4'd2, 4'd1);
      tbl[10] = mkv(1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b1, CtlBranch, 4'd2, 4'd1);
      tbl[11] = mkv(1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, CtlNorm,   4'd2, 4'd2);
      for (int i = 0; i < 12; i++) apply(tbl[i], "vec", i);

      // Mul/div: freeze cycles 1-4, branch in cycle 3 ignored, release in cycle 5.
      rst_pulse();
      apply(mkv(1'b0, 5'd21, 5'd0, 1'b1, 1'b0, 5'd21, 1'b1, 1'b0, 1'b1, CtlMdGo, 4'd0, 4'd0),
            "md", 1);
      apply(mkv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, CtlMdWait, 4'd1, 4'd0),
            "md", 2);
      apply(mkv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, CtlMdWait, 4'd2, 4'd0),
            "md", 3);
      apply(mkv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, CtlMdDone, 4'd3, 4'd0),
            "md", 4);
      apply(mkv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, CtlNorm, 4'd4, 4'd0),
            "md", 5);

      // Reset in cycle 3 of a mul/div aborts it.
      rst_pulse();
      apply(mkv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, CtlMdGo, 4'd0, 4'd0),
            "mdrst", 1);
      apply(mkv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, CtlMdWait, 4'd1, 4'd0),
            "mdrst", 2);
      apply(mkv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, CtlRst, 4'd2, 4'd0),
            "mdrst", 3);
      apply(mkv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, CtlNorm, 4'd0, 4'd0),
            "mdrst", 4);
      apply(mkv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, CtlNorm, 4'd0, 4'd0),
            "mdrst", 5);

      // 20 back-to-back load-use stalls saturate the 4-bit counter at 15.
      rst_pulse();
      for (int i = 0; i < 20; i++) begin
         apply(mkv(1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, CtlLdUse,
                   (i < 15) ? 4'(i) : 4'd15, 4'd0), "sat", i);
      end
      apply(mkv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, CtlNorm, 4'd15, 4'd0),
            "sat", 20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
